// File: rtl/tcs3472_reader_pkg.sv
// Shared definitions for the TCS3472 colour-sensor reader: register map,
// command encoding and the FSM state/phase encodings.
package tcs3472_reader_pkg;

  localparam logic [7:0] CMD_BIT    = 8'h80;
  localparam logic [7:0] ENABLE_VAL = 8'h03;  // PON | AEN

  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_ATIME  = 8'h01;
  localparam logic [7:0] REG_CDATAL = 8'h14;
  localparam logic [7:0] REG_CDATAH = 8'h15;
  localparam logic [7:0] REG_RDATAL = 8'h16;
  localparam logic [7:0] REG_RDATAH = 8'h17;
  localparam logic [7:0] REG_GDATAL = 8'h18;
  localparam logic [7:0] REG_GDATAH = 8'h19;
  localparam logic [7:0] REG_BDATAL = 8'h1A;
  localparam logic [7:0] REG_BDATAH = 8'h1B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG_EN  = 3'd1,
    ST_CFG_AT  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_ACK  = 3'd5,
    ST_RD_REL  = 3'd6,
    ST_PUBLISH = 3'd7
  } state_t;

  // Sub-phases of a configuration write: wait for done low and raise start,
  // hold start until done, then wait for done to fall again.
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_ACK   = 2'd1,
    PH_REL   = 2'd2
  } phase_t;

  // Command byte for data byte k (CDATAL first, BDATAH last).
  function automatic logic [7:0] data_cmd(input logic [2:0] k);
    logic [7:0] r;
    case (k)
      3'd0:    r = REG_CDATAL;
      3'd1:    r = REG_CDATAH;
      3'd2:    r = REG_RDATAL;
      3'd3:    r = REG_RDATAH;
      3'd4:    r = REG_GDATAL;
      3'd5:    r = REG_GDATAH;
      3'd6:    r = REG_BDATAL;
      default: r = REG_BDATAH;
    endcase
    return CMD_BIT | r;
  endfunction

endpackage

// File: rtl/i2c_txn_timer.sv
// Loadable down-counter shared between the inter-sample wait and the
// per-transaction timeout. expire is high while the count is 0 or 1, so a
// load of N followed by N decrementing cycles ends on the Nth cycle.
module i2c_txn_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count[W-1:1] == '0);

endmodule

// File: rtl/tcs3472_reader.sv
// TCS3472 reader: enables the sensor, programs ATIME, then periodically reads
// the eight colour data bytes and publishes all four channels at once.
//
// Handshake with the I2C master: i2c_start is raised together with stable
// i2c_rw/i2c_reg/i2c_wdata and only when i2c_done is low; it is held until
// i2c_done is sampled high (read data captured on that same clock), then
// dropped, and no new request is made until i2c_done has returned low.
module tcs3472_reader
  import tcs3472_reader_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h29,
  parameter logic [7:0]  ATIME_VAL      = 8'hF6,
  parameter logic [23:0] WAIT_CYCLES    = 24'd125000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        i2c_start,
  output logic        i2c_rw,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  output logic [15:0] clear,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        valid,
  output logic        busy,
  output logic        err,
  output state_t      dbg_state
);

  state_t      state, next_state;
  phase_t      phase, next_phase;
  logic        next_start, next_rw;
  logic [7:0]  next_reg, next_wdata;
  logic [2:0]  k, next_k;
  logic [63:0] shadow, next_shadow;
  logic        next_valid, next_err;
  logic        tmo, next_tmo;
  logic        tmr_load, tmr_dec, tmr_expire;
  logic [23:0] tmr_val;

  assign i2c_addr  = SLAVE_ADDR;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  i2c_txn_timer #(.W(24)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  // State, handshake outputs, shadow bytes and published channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_ISSUE;
      i2c_start <= 1'b0;
      i2c_rw    <= 1'b0;
      i2c_reg   <= 8'h00;
      i2c_wdata <= 8'h00;
      k         <= 3'd0;
      shadow    <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      clear     <= 16'h0000;
      red       <= 16'h0000;
      green     <= 16'h0000;
      blue      <= 16'h0000;
    end else begin
      state     <= next_state;
      phase     <= next_phase;
      i2c_start <= next_start;
      i2c_rw    <= next_rw;
      i2c_reg   <= next_reg;
      i2c_wdata <= next_wdata;
      k         <= next_k;
      shadow    <= next_shadow;
      valid     <= next_valid;
      err       <= next_err;
      tmo       <= next_tmo;
      if (next_valid) begin
        clear <= shadow[15:0];
        red   <= shadow[31:16];
        green <= shadow[47:32];
        blue  <= shadow[63:48];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    next_state  = state;
    next_phase  = phase;
    next_start  = i2c_start;
    next_rw     = i2c_rw;
    next_reg    = i2c_reg;
    next_wdata  = i2c_wdata;
    next_k      = k;
    next_shadow = shadow;
    next_valid  = 1'b0;
    next_err    = err;
    next_tmo    = tmo;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = TIMEOUT_CYCLES;

    case (state)
      ST_IDLE: begin
        if (run) begin
          next_state = ST_CFG_EN;
          next_phase = PH_ISSUE;
          next_err   = 1'b0;
        end
      end

      ST_CFG_EN, ST_CFG_AT: begin
        case (phase)
          PH_ISSUE: begin
            if (!run) begin
              next_state = ST_IDLE;
            end else if (!i2c_done) begin
              next_start = 1'b1;
              next_rw    = 1'b0;
              next_reg   = (state == ST_CFG_EN) ? (CMD_BIT | REG_ENABLE)
                                                : (CMD_BIT | REG_ATIME);
              next_wdata = (state == ST_CFG_EN) ? ENABLE_VAL : ATIME_VAL;
              tmr_load   = 1'b1;
              next_phase = PH_ACK;
            end
          end
          PH_ACK: begin
            tmr_dec = 1'b1;
            if (i2c_done) begin
              next_start = 1'b0;
              next_phase = PH_REL;
            end else if (tmr_expire) begin
              next_start  = 1'b0;
              next_err    = 1'b1;
              next_tmo    = 1'b1;
              next_shadow = '0;
              next_phase  = PH_REL;
            end
          end
          PH_REL: begin
            if (!i2c_done) begin
              next_phase = PH_ISSUE;
              if (tmo) begin
                next_tmo = 1'b0;
                if (run) begin
                  next_state = ST_CFG_EN;
                  next_err   = 1'b0;
                end else begin
                  next_state = ST_IDLE;
                end
              end else if (!run) begin
                next_state = ST_IDLE;
              end else if (state == ST_CFG_EN) begin
                next_state = ST_CFG_AT;
              end else begin
                next_state = ST_WAIT;
                tmr_load   = 1'b1;
                tmr_val    = WAIT_CYCLES;
              end
            end
          end
          default: next_phase = PH_ISSUE;
        endcase
      end

      ST_WAIT: begin
        if (!run) begin
          next_state = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            next_state  = ST_RD_REQ;
            next_k      = 3'd0;
            next_shadow = '0;
          end
        end
      end

      ST_RD_REQ: begin
        if (!run) begin
          next_state  = ST_IDLE;
          next_shadow = '0;
        end else if (!i2c_done) begin
          next_start = 1'b1;
          next_rw    = 1'b1;
          next_reg   = data_cmd(k);
          next_wdata = 8'h00;
          tmr_load   = 1'b1;
          next_state = ST_RD_ACK;
        end
      end

      ST_RD_ACK: begin
        tmr_dec = 1'b1;
        if (i2c_done) begin
          next_shadow[{k, 3'b000} +: 8] = i2c_rdata;
          next_start = 1'b0;
          next_state = ST_RD_REL;
        end else if (tmr_expire) begin
          next_start  = 1'b0;
          next_err    = 1'b1;
          next_tmo    = 1'b1;
          next_shadow = '0;
          next_state  = ST_RD_REL;
        end
      end

      ST_RD_REL: begin
        if (!i2c_done) begin
          if (tmo) begin
            next_tmo    = 1'b0;
            next_shadow = '0;
            if (run) begin
              next_state = ST_CFG_EN;
              next_phase = PH_ISSUE;
              next_err   = 1'b0;
            end else begin
              next_state = ST_IDLE;
            end
          end else if (!run) begin
            next_state  = ST_IDLE;
            next_shadow = '0;
          end else if (k == 3'd7) begin
            next_state = ST_PUBLISH;
            next_valid = 1'b1;
          end else begin
            next_k     = k + 3'd1;
            next_state = ST_RD_REQ;
          end
        end
      end

      ST_PUBLISH: begin
        if (run) begin
          next_state = ST_WAIT;
          tmr_load   = 1'b1;
          tmr_val    = WAIT_CYCLES;
        end else begin
          next_state = ST_IDLE;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tcs3472_reader.sv
// Testbench for tcs3472_reader: I2C master model answering from a byte queue,
// transaction and sample-set scoreboards, one task per scenario.
module tb_tcs3472_reader;
  import tcs3472_reader_pkg::*;

  localparam int WAIT_C = 20;
  localparam int TMO_C  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        i2c_start, i2c_rw;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg, i2c_wdata;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        i2c_done = 1'b0;
  logic [15:0] clear, red, green, blue;
  logic        valid, busy, err;
  state_t      dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // master model / monitor state
  int   cyc = 0;
  logic ack_en = 1'b1;
  int   done_hold = 1;
  int   lat = 0, hold = 0;
  logic start_seen = 1'b0;
  int   txn_count = 0, violations = 0, valid_count = 0;
  int   start_rise_cyc = 0;
  logic [7:0]  byte_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic [63:0] exp_data_q[$];
  logic [63:0] obs_data_q[$];

  tcs3472_reader #(
    .SLAVE_ADDR(7'h29), .ATIME_VAL(8'hF6),
    .WAIT_CYCLES(24'(WAIT_C)), .TIMEOUT_CYCLES(24'(TMO_C))
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr),
    .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .i2c_done(i2c_done), .clear(clear), .red(red), .green(green),
    .blue(blue), .valid(valid), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // I2C master model and output monitor, acting on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      i2c_done = 1'b0; i2c_rdata = 8'h00; start_seen = 1'b0; lat = 0; hold = 0;
    end else begin
      if (i2c_start && !start_seen) begin
        start_seen = 1'b1; lat = 2; txn_count++; start_rise_cyc = cyc;
        obs_q.push_back({i2c_rw, i2c_reg, (i2c_rw ? 8'h00 : i2c_wdata)});
        if (i2c_done) violations++;
      end else if (!i2c_start) begin
        start_seen = 1'b0;
      end
      if (ack_en) begin
        if (i2c_start && !i2c_done) begin
          if (lat > 0) lat--;
          else begin
            i2c_done = 1'b1; hold = done_hold;
            if (i2c_rw) begin
              if (byte_q.size() > 0) i2c_rdata = byte_q.pop_front();
              else i2c_rdata = 8'h00;
            end
          end
        end else if (i2c_done) begin
          if (hold > 1) hold--;
          else if (!i2c_start) begin i2c_done = 1'b0; i2c_rdata = 8'h00; end
        end
      end
    end
    if (valid) begin
      valid_count++;
      obs_data_q.push_back({blue, green, red, clear});
    end
  end

  // push one sample set: bytes to the model, expected channels to the scoreboard
  task automatic push_set(input logic [63:0] s);
    for (int b = 0; b < 8; b++) byte_q.push_back(s[b*8 +: 8]);
    exp_data_q.push_back(s);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && busy; i++) @(negedge clk);
    tests_run++;
    if (busy) begin tests_failed++; $display("FAIL idle_timeout: busy=%0b required 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({i2c_start, i2c_rw, i2c_reg, i2c_wdata, valid, busy, err} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h required 0", {i2c_start, i2c_rw, i2c_reg, i2c_wdata, valid, busy, err});
    end
    tests_run++;
    if ({clear, red, green, blue} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_data: got %h required 0", {clear, red, green, blue});
    end
    tests_run++;
    if (i2c_addr !== 7'h29) begin tests_failed++; $display("FAIL addr: got %h required 29", i2c_addr); end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_config_and_read();
    logic [63:0] s, got;
    logic [16:0] e, o;
    int i;
    obs_q.delete(); exp_q.delete(); byte_q.delete(); exp_data_q.delete(); obs_data_q.delete();
    exp_q.push_back({1'b0, 8'h80, 8'h03});
    exp_q.push_back({1'b0, 8'h81, 8'hF6});
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 8'h94 + 8'(k), 8'h00});
    push_set(64'h8877_6655_4433_2211);
    for (int n = 0; n < 3; n++) begin
      s = {$urandom_range(0, 32'hFFFF_FFFF), $urandom_range(0, 32'hFFFF_FFFF)};
      push_set(s);
    end
    valid_count = 0;
    run = 1'b1;
    for (i = 0; i < 5000 && obs_data_q.size() < 4; i++) @(negedge clk);
    run = 1'b0;
    wait_idle(200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL txn_missing: no transaction seen, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL txn_order: got %h required %h", o, e); end
      end
    end
    tests_run++;
    if (obs_data_q.size() != 4) begin
      tests_failed++; $display("FAIL set_count: got %0d required 4", obs_data_q.size());
    end
    tests_run++;
    if (valid_count != 4) begin tests_failed++; $display("FAIL valid_pulses: got %0d required 4", valid_count); end
    tests_run++;
    if (obs_data_q.size() > 0 && obs_data_q[0][15:0] !== 16'h2211) begin
      tests_failed++; $display("FAIL clear_value: got %h required 2211", obs_data_q[0][15:0]);
    end
    tests_run++;
    if (obs_data_q.size() > 0 && obs_data_q[0][63:16] !== 48'h8877_6655_4433) begin
      tests_failed++; $display("FAIL rgb_value: got %h required 887766554433", obs_data_q[0][63:16]);
    end
    while (exp_data_q.size() > 0 && obs_data_q.size() > 0) begin
      s = exp_data_q.pop_front(); got = obs_data_q.pop_front();
      tests_run++;
      if (got !== s) begin tests_failed++; $display("FAIL sample_set: got %h required %h", got, s); end
    end
  endtask

  task automatic test_done_hold();
    int base, i;
    done_hold = 500; violations = 0; byte_q.delete();
    base = txn_count;
    run = 1'b1;
    for (i = 0; i < 50 && txn_count == base; i++) @(negedge clk);
    repeat (400) @(negedge clk);
    tests_run++;
    if (txn_count - base != 1) begin
      tests_failed++; $display("FAIL hold_txn_count: got %0d required 1", txn_count - base);
    end
    tests_run++;
    if ({i2c_start, i2c_done} !== 2'b01) begin
      tests_failed++; $display("FAIL hold_start_low: got start,done=%b required 01", {i2c_start, i2c_done});
    end
    done_hold = 1;
    for (i = 0; i < 300 && txn_count - base < 2; i++) @(negedge clk);
    tests_run++;
    if (txn_count - base != 2) begin
      tests_failed++; $display("FAIL hold_second_txn: got %0d required 2", txn_count - base);
    end
    tests_run++;
    if (violations != 0) begin tests_failed++; $display("FAIL start_while_done: got %0d required 0", violations); end
    run = 1'b0;
    wait_idle(200);
  endtask

  task automatic test_timeout();
    int i, rise;
    ack_en = 1'b0;
    run = 1'b1;
    for (i = 0; i < 1500 && !err; i++) @(negedge clk);
    rise = cyc - start_rise_cyc;
    tests_run++;
    if (!err || rise != TMO_C) begin
      tests_failed++; $display("FAIL timeout_cycle: err=%0b after %0d cycles required 1 after %0d", err, rise, TMO_C);
    end
    tests_run++;
    if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL timeout_start: got %0b required 0", i2c_start); end
    @(negedge clk);
    tests_run++;
    if ({err, dbg_state} !== {1'b0, ST_CFG_EN}) begin
      tests_failed++; $display("FAIL timeout_restart: got err=%0b state=%0d required 0/1", err, dbg_state);
    end
    for (i = 0; i < 10 && !i2c_start; i++) @(negedge clk);
    tests_run++;
    if ({i2c_start, i2c_reg} !== {1'b1, 8'h80}) begin
      tests_failed++; $display("FAIL timeout_reissue: got start=%0b reg=%h required 1/80", i2c_start, i2c_reg);
    end
    run = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_drop();
    logic [63:0] a, b;
    int i, vbase;
    byte_q.delete(); exp_data_q.delete(); obs_data_q.delete(); obs_q.delete();
    a = {$urandom_range(0, 32'hFFFF_FFFF), $urandom_range(0, 32'hFFFF_FFFF)};
    b = ~a;
    push_set(a); push_set(b);
    vbase = valid_count;
    run = 1'b1;
    for (i = 0; i < 2000 && obs_data_q.size() < 1; i++) @(negedge clk);
    for (i = 0; i < 500 && !(i2c_start && i2c_reg == 8'h97); i++) @(negedge clk);
    run = 1'b0;
    wait_idle(200);
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid_count - vbase != 1) begin
      tests_failed++; $display("FAIL drop_valid: got %0d pulses required 1", valid_count - vbase);
    end
    tests_run++;
    if (byte_q.size() != 4) begin
      tests_failed++; $display("FAIL drop_bytes_left: got %0d required 4", byte_q.size());
    end
    tests_run++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {1'b1, 8'h97, 8'h00}) begin
      tests_failed++; $display("FAIL drop_last_txn: got %0d txns, required last read reg 97", obs_q.size());
    end
    tests_run++;
    if ({blue, green, red, clear} !== a) begin
      tests_failed++; $display("FAIL drop_retain: got %h required %h", {blue, green, red, clear}, a);
    end
  endtask

  task automatic test_rst_cfg_at();
    int i;
    run = 1'b1;
    for (i = 0; i < 200 && !(dbg_state == ST_CFG_AT && i2c_start); i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({i2c_start, i2c_rw, i2c_reg, i2c_wdata, valid, busy, err} !== 21'd0) begin
      tests_failed++;
      $display("FAIL rst_ctrl: got %h required 0", {i2c_start, i2c_rw, i2c_reg, i2c_wdata, valid, busy, err});
    end
    tests_run++;
    if ({clear, red, green, blue} !== 64'd0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL rst_data: got %h state %0d required 0", {clear, red, green, blue}, dbg_state);
    end
    rst = 1'b0;
    for (i = 0; i < 20 && !i2c_start; i++) @(negedge clk);
    tests_run++;
    if ({i2c_start, i2c_reg, dbg_state} !== {1'b1, 8'h80, ST_CFG_EN}) begin
      tests_failed++; $display("FAIL rst_restart: got start=%0b reg=%h state=%0d required 1/80/1", i2c_start, i2c_reg, dbg_state);
    end
    run = 1'b0;
    wait_idle(200);
  endtask

  initial begin
    test_reset();
    test_config_and_read();
    test_done_hold();
    test_timeout();
    test_run_drop();
    test_rst_cfg_at();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tcs3472_reader.md
TCS3472_READER -- requirements
Module: tcs3472_reader

Interface
REQ-001 Parameter SLAVE_ADDR, 7'h29, 7-bit I2C address driven on addr.
REQ-002 Parameter ATIME_VAL, 8'hF6, value written to ATIME register.
REQ-003 Parameter WAIT_CYCLES, 24'd125000, clk cycles between end of one sample set and start of the next.
REQ-004 Parameter TIMEOUT_CYCLES, 24'd2000000, maximum clk cycles allowed for one I2C transaction.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 run  input  1  level; 1 = configure sensor and sample continuously.
REQ-008 i2c_start  output  1  transaction request to the I2C master.
REQ-009 i2c_rw  output  1  0 = write, 1 = read.
REQ-010 i2c_addr  output  7  always SLAVE_ADDR.
REQ-011 i2c_reg  output  8  command byte (0x80 | register).
REQ-012 i2c_wdata  output  8  write data.
REQ-013 i2c_rdata  input  8  read data, valid while i2c_done=1.
REQ-014 i2c_done  input  1  transaction complete, level, may stay high many clk cycles.
REQ-015 clear, red, green, blue  output  16 each  last complete sample set.
REQ-016 valid  output  1  one-clk pulse when all four channels update.
REQ-017 busy  output  1  1 whenever state is not IDLE.
REQ-018 err  output  1  sticky timeout flag, cleared on entry to CFG_EN.

Function
REQ-019 States: IDLE, CFG_EN, CFG_AT, WAIT, RD_REQ, RD_ACK, RD_REL, PUBLISH.
REQ-020 IDLE -> CFG_EN when run=1; any state except PUBLISH -> IDLE at the next transaction boundary (REL phase) or immediately from WAIT when run=0.
REQ-021 CFG_EN: write reg 8'h80, data 8'h03 (PON|AEN); CFG_AT: write reg 8'h81, data ATIME_VAL; then WAIT.
REQ-022 Transaction handshake: assert i2c_start with stable rw/reg/wdata; hold until i2c_done=1 sampled; deassert i2c_start; wait until i2c_done=0 before any new request.
REQ-023 i2c_rdata is captured on the first clk where i2c_done=1 during a read.
REQ-024 Read sequence: 8 single-byte reads, byte index k=0..7, reg = 8'h80 | (8'h14 + k): CDATAL, CDATAH, RDATAL, RDATAH, GDATAL, GDATAH, BDATAL, BDATAH.
REQ-025 Bytes accumulate in a shadow register; low byte at even k, high byte at odd k; outputs clear/red/green/blue update only in PUBLISH, all four in the same cycle.
REQ-026 PUBLISH lasts one clk, pulses valid, returns to WAIT (or IDLE if run=0).
REQ-027 WAIT counts WAIT_CYCLES clk cycles, then starts read k=0; counter reloads on each entry.
REQ-028 Timeout counter runs from i2c_start assertion; reaching TIMEOUT_CYCLES sets err, drops i2c_start, discards shadow data, and returns to CFG_EN after i2c_done=0.
REQ-029 run falling mid-read: current transaction completes per REQ-022, partial shadow data is discarded, valid not pulsed.

Reset
REQ-030 On rst: state IDLE, i2c_start 0, i2c_rw 0, i2c_reg 0, i2c_wdata 0, clear/red/green/blue 0, valid 0, busy 0, err 0, all counters 0.
REQ-031 rst asserted mid-transaction takes effect immediately; no handshake completion is awaited.

Structure
REQ-032 Shared package holds TCS3472 register addresses (ENABLE, ATIME, CDATAL..BDATAH), CMD_BIT 8'h80, ENABLE_VAL 8'h03 and the state encoding.
REQ-033 One sub-module, i2c_txn_timer: loadable down-counter used for both WAIT and timeout.
REQ-034 Single clock domain; i2c_rdata/i2c_done are assumed synchronous to clk.

Verification
REQ-035 run=1, master model acks all -> writes (80,03) then (81,F6) observed in order, then 8 reads regs 94..9B.
REQ-036 Model returns bytes 11,22,33,44,55,66,77,88 -> valid pulse once; clear=2211, red=4433, green=6655, blue=8877.
REQ-037 i2c_done held high 500 clk -> exactly one transaction counted, no new i2c_start until done=0.
REQ-038 Model never asserts done, TIMEOUT_CYCLES=1000 -> err=1 at cycle 1000, i2c_start=0, restart at CFG_EN clears err.
REQ-039 run=0 during read k=3 -> transaction finishes, IDLE, no valid, outputs retain previous set.
REQ-040 rst pulse during CFG_AT -> all outputs at REQ-030 values next clk; run still 1 restarts at CFG_EN.
